// File: rtl/cdb_arbiter.sv
// Common data bus producer: per-source writeback FIFOs feeding up to NUM_CDB
// round-robin-granted broadcast lanes per cycle. The CDB has no backpressure.
module cdb_arbiter #(
  parameter int NUM_SRC    = 6,
  parameter int NUM_CDB    = 4,
  parameter int TAG_W      = 6,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic [NUM_SRC-1:0]   wb_valid,
  output logic [NUM_SRC-1:0]   wb_ready,
  input  logic [TAG_W-1:0]     wb_tag [0:NUM_SRC-1],
  input  logic [DATA_W-1:0]    wb_val [0:NUM_SRC-1],
  output logic [NUM_CDB-1:0]   cdb_valid,
  output logic [TAG_W-1:0]     cdb_tag [0:NUM_CDB-1],
  output logic [DATA_W-1:0]    cdb_val [0:NUM_CDB-1],
  output logic [SRC_W-1:0]     rr_ptr_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Handshake: a source pushes on an edge where wb_valid & wb_ready are both high;
  // wb_ready depends only on registered occupancy and flush, never on this cycle's grant.
  logic [TAG_W-1:0]  tag_q [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] val_q [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q  [NUM_SRC];
  logic [PTR_W-1:0]  rd_q  [NUM_SRC];
  logic [CNT_W-1:0]  cnt_q [NUM_SRC];
  logic [SRC_W-1:0]  rr_q, rr_d;
  logic [NUM_SRC-1:0] push_w, grant_w;
  logic              any_grant;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      wb_ready[i] = (cnt_q[i] < CNT_W'(FIFO_DEPTH)) && !flush_i;
      push_w[i]   = wb_valid[i] && wb_ready[i];
    end
  end

  // Scan from rr_q with wrap; the k-th non-empty source found drives lane k.
  always_comb begin
    int idx, n, last;
    grant_w   = '0;
    cdb_valid = '0;
    any_grant = 1'b0;
    n         = 0;
    last      = 0;
    idx       = 0;
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_tag[k] = '0;
      cdb_val[k] = '0;
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      idx = int'(rr_q) + j;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!flush_i && (cnt_q[idx] != '0) && (n < NUM_CDB)) begin
        grant_w[idx] = 1'b1;
        cdb_valid[n] = 1'b1;
        cdb_tag[n]   = tag_q[idx][rd_q[idx]];
        cdb_val[n]   = val_q[idx][rd_q[idx]];
        any_grant    = 1'b1;
        last         = idx;
        n            = n + 1;
      end
    end
    rr_d = any_grant ? SRC_W'((last + 1) % NUM_SRC) : rr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else if (flush_i) begin
      rr_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push_w[i])  wr_q[i] <= wr_q[i] + PTR_W'(1);
        if (grant_w[i]) rd_q[i] <= rd_q[i] + PTR_W'(1);
        cnt_q[i] <= cnt_q[i] + CNT_W'(push_w[i]) - CNT_W'(grant_w[i]);
      end
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_w[i]) begin
        tag_q[i][wr_q[i]] <= wb_tag[i];
        val_q[i][wr_q[i]] <= wb_val[i];
      end
    end
  end

  assign rr_ptr_o = rr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table for arbitration sequences plus
// hand-written reset, flush, saturation and push/pop-same-edge sequences.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i;
  logic [5:0]  wb_valid;
  logic [5:0]  wb_ready;
  logic [5:0]  wb_tag [0:5];
  logic [31:0] wb_val [0:5];
  logic [3:0]  cdb_valid;
  logic [5:0]  cdb_tag [0:3];
  logic [31:0] cdb_val [0:3];
  logic [2:0]  rr_ptr_o;

  int n_cmp  = 0;
  int n_fail = 0;

  cdb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_val(wb_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .rr_ptr_o(rr_ptr_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            flush;
    logic [5:0]      mask;
    logic [5:0]      base;
    logic [3:0]      ev;
    logic [3:0][5:0] et;
    logic [5:0]      er;
    logic [2:0]      err;
  } vec_t;

  vec_t vecs[$];
  logic [5:0] exp_q[$];

  function automatic logic [31:0] val_of(input logic [5:0] tag);
    return 32'hC0DE_0000 | (32'(tag) << 8) | 32'(tag);
  endfunction

  function automatic logic [31:0] vsrc(input int src, input logic [5:0] tag);
    return 32'h7700_0000 | (32'(src) << 16) | 32'(tag);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [5:0] mask, input logic [5:0] base);
    flush_i  = fl;
    wb_valid = mask;
    for (int i = 0; i < 6; i++) begin
      wb_tag[i] = base + 6'(i);
      wb_val[i] = val_of(base + 6'(i));
    end
  endtask

  task automatic add(input logic fl, input logic [5:0] mask, input logic [5:0] base,
                     input logic [3:0] ev, input logic [5:0] t0, input logic [5:0] t1,
                     input logic [5:0] t2, input logic [5:0] t3,
                     input logic [5:0] er, input logic [2:0] err);
    vec_t v;
    v.flush = fl; v.mask = mask; v.base = base; v.ev = ev;
    v.et[0] = t0; v.et[1] = t1; v.et[2] = t2; v.et[3] = t3;
    v.er = er; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] mcnt [6];
    int         wait_c [6];
    logic [5:0] push_m, pop_m, exp_rdy;
    logic [3:0] exp_v;
    int         nz, s0_idx, src, max_wait;

    drive(1'b0, 6'h00, 6'd0);

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cdb_valid", 32'(cdb_valid), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_wb_ready", 32'(wb_ready), 32'h3F);
    chk("rst_rr_ptr", 32'(rr_ptr_o), 32'h0);
    chk("rst_lane0_tag", 32'(cdb_tag[0]), 32'h0);

    // flush, mask, base, exp valid, lane tags 0..3, exp ready, exp rr
    add(0, 6'h04,  3, 4'b0001,  5,  0,  0,  0, 6'h3F, 0);
    add(0, 6'h00,  0, 4'b0000,  0,  0,  0,  0, 6'h3F, 3);
    add(0, 6'h3F,  1, 4'b1111,  4,  5,  6,  1, 6'h3F, 3);
    add(0, 6'h00,  0, 4'b0011,  2,  3,  0,  0, 6'h3F, 1);
    add(0, 6'h00,  0, 4'b0000,  0,  0,  0,  0, 6'h3F, 3);
    add(1, 6'h00,  0, 4'b0000,  0,  0,  0,  0, 6'h3F, 0);
    add(0, 6'h3F,  1, 4'b1111,  1,  2,  3,  4, 6'h3F, 0);
    add(0, 6'h00,  0, 4'b0011,  5,  6,  0,  0, 6'h3F, 4);
    add(0, 6'h00,  0, 4'b0000,  0,  0,  0,  0, 6'h3F, 0);
    add(0, 6'h3F, 10, 4'b1111, 10, 11, 12, 13, 6'h3F, 0);
    add(0, 6'h3F, 20, 4'b1111, 14, 15, 20, 21, 6'h0F, 4);
    add(0, 6'h3F, 30, 4'b1111, 22, 23, 24, 25, 6'h33, 2);
    add(0, 6'h00,  0, 4'b1111, 30, 31, 32, 33, 6'h3F, 0);
    add(0, 6'h00,  0, 4'b0000,  0,  0,  0,  0, 6'h3F, 4);

    foreach (vecs[s]) begin
      drive(vecs[s].flush, vecs[s].mask, vecs[s].base);
      step_edge();
      drive(1'b0, 6'h00, 6'd0);
      #1;
      chk($sformatf("vec%0d_valid", s), 32'(cdb_valid), 32'(vecs[s].ev));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("vec%0d_tag%0d", s, k), 32'(cdb_tag[k]),
            vecs[s].ev[k] ? 32'(vecs[s].et[k]) : 32'h0);
        chk($sformatf("vec%0d_val%0d", s, k), cdb_val[k],
            vecs[s].ev[k] ? val_of(vecs[s].et[k]) : 32'h0);
      end
      chk($sformatf("vec%0d_ready", s), 32'(wb_ready), 32'(vecs[s].er));
      chk($sformatf("vec%0d_rr", s), 32'(rr_ptr_o), 32'(vecs[s].err));
    end

    // Single result: visible the cycle after acceptance, gone the cycle after that
    wb_valid = 6'h04; wb_tag[2] = 6'd5; wb_val[2] = 32'hDEADBEEF;
    step_edge();
    drive(1'b0, 6'h00, 6'd0);
    #1;
    chk("single_valid", 32'(cdb_valid), 32'h1);
    chk("single_tag", 32'(cdb_tag[0]), 32'd5);
    chk("single_val", cdb_val[0], 32'hDEADBEEF);
    step_edge();
    chk("single_gone", 32'(cdb_valid), 32'h0);

    // src0 sends 10,11,12 while src1-5 saturate; occupancy model drives ready/lane checks
    for (int i = 0; i < 6; i++) begin mcnt[i] = '0; wait_c[i] = 0; end
    s0_idx = 0;
    max_wait = 0;
    for (int c = 0; c < 20; c++) begin
      flush_i = 1'b0;
      wb_valid = '0;
      if (s0_idx < 3) begin
        wb_valid[0] = 1'b1;
        wb_tag[0] = 6'(10 + s0_idx);
        wb_val[0] = vsrc(0, 6'(10 + s0_idx));
      end
      for (int i = 1; i < 6; i++) begin
        wb_valid[i] = (c < 8);
        wb_tag[i] = 6'(32 + i);
        wb_val[i] = vsrc(i, 6'(32 + i));
      end
      #1;
      nz = 0;
      for (int i = 0; i < 6; i++) begin
        exp_rdy[i] = (mcnt[i] < 6'd2);
        if (mcnt[i] != 0) nz++;
      end
      exp_v = 4'((1 << ((nz > 4) ? 4 : nz)) - 1);
      chk($sformatf("sat%0d_ready", c), 32'(wb_ready), 32'(exp_rdy));
      chk($sformatf("sat%0d_valid", c), 32'(cdb_valid), 32'(exp_v));
      pop_m = '0;
      for (int k = 0; k < 4; k++) begin
        if (cdb_valid[k]) begin
          src = int'(cdb_val[k][18:16]);
          if (src < 6) pop_m[src] = 1'b1;
          chk($sformatf("sat%0d_lane%0d_pair", c, k), 32'(cdb_val[k][5:0]), 32'(cdb_tag[k]));
          if (src == 0) begin
            if (exp_q.size() > 0)
              chk($sformatf("sat%0d_src0_order", c), 32'(cdb_tag[k]), 32'(exp_q.pop_front()));
            else
              chk($sformatf("sat%0d_src0_extra", c), 32'(cdb_tag[k]), 32'h3F);
          end
        end
      end
      for (int i = 0; i < 6; i++) begin
        if (mcnt[i] != 0 && !pop_m[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
      push_m = wb_valid & exp_rdy;
      if (push_m[0]) exp_q.push_back(wb_tag[0]);
      step_edge();
      if (push_m[0]) s0_idx++;
      for (int i = 0; i < 6; i++)
        mcnt[i] = mcnt[i] + 6'(push_m[i]) - 6'(pop_m[i]);
    end
    drive(1'b0, 6'h00, 6'd0);
    chk("sat_src0_sent", 32'(s0_idx), 32'd3);
    chk("sat_src0_drained", 32'(exp_q.size()), 32'd0);
    chk("sat_max_wait", 32'(max_wait <= 1), 32'd1);
    #1;
    chk("sat_idle_valid", 32'(cdb_valid), 32'h0);

    // Flush with every FIFO occupied
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 6'h3F, 6'd40);
      step_edge();
    end
    drive(1'b0, 6'h00, 6'd0);
    #1;
    chk("flush_pre_valid", 32'(cdb_valid), 32'hF);
    drive(1'b1, 6'h3F, 6'd50);
    #1;
    chk("flush_valid", 32'(cdb_valid), 32'h0);
    chk("flush_ready", 32'(wb_ready), 32'h0);
    step_edge();
    drive(1'b0, 6'h00, 6'd0);
    #1;
    chk("flush_post_valid", 32'(cdb_valid), 32'h0);
    chk("flush_post_ready", 32'(wb_ready), 32'h3F);
    chk("flush_post_rr", 32'(rr_ptr_o), 32'h0);
    step_edge();
    chk("flush_post2_valid", 32'(cdb_valid), 32'h0);

    // src5: push and pop on the same edge with one entry held
    wb_valid = 6'h20; wb_tag[5] = 6'd7; wb_val[5] = val_of(6'd7);
    step_edge();
    wb_tag[5] = 6'd8; wb_val[5] = val_of(6'd8);
    #1;
    chk("pp_first_valid", 32'(cdb_valid), 32'h1);
    chk("pp_first_tag", 32'(cdb_tag[0]), 32'd7);
    chk("pp_first_ready", 32'(wb_ready), 32'h3F);
    step_edge();
    drive(1'b0, 6'h00, 6'd0);
    #1;
    chk("pp_second_valid", 32'(cdb_valid), 32'h1);
    chk("pp_second_tag", 32'(cdb_tag[0]), 32'd8);
    chk("pp_second_val", cdb_val[0], val_of(6'd8));
    chk("pp_second_ready", 32'(wb_ready), 32'h3F);
    step_edge();
    chk("pp_empty_valid", 32'(cdb_valid), 32'h0);

    // Reset while FIFOs hold data
    drive(1'b0, 6'h3F, 6'd1);
    step_edge();
    drive(1'b0, 6'h00, 6'd0);
    #1;
    chk("mrst_pre_valid", 32'(cdb_valid), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(cdb_valid), 32'h0);
    chk("mrst_tag0", 32'(cdb_tag[0]), 32'h0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("mrst_ready", 32'(wb_ready), 32'h3F);
    step_edge();
    chk("mrst_post_valid", 32'(cdb_valid), 32'h0);
    chk("mrst_post_rr", 32'(rr_ptr_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

endmodule
